// File: rtl/tl_pkg.sv
// Shared constants and FSM encoding for the transaction-layer pop statistics stage.
package tl_pkg;

  localparam int unsigned DEF_NUM_FIFOS = 4;
  localparam int unsigned DEF_CNT_W     = 5;
  localparam int unsigned DEF_IDX_W     = 3;

  localparam logic [DEF_IDX_W-1:0] IDX_TOTAL = 3'd4;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_READY = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Enable/clear up-counter that holds at all-ones and flags saturation until cleared.
module sat_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (en && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == '1) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/pop_counter.sv
// Per-FIFO pop statistics with an idle-gated req/idx read port (one-cycle registered response).
module pop_counter
  import tl_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned IDX_W     = DEF_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 idle,
  input  logic [NUM_FIFOS-1:0] pop,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic                 req,
  input  logic [IDX_W-1:0]     idx,
  output logic [CNT_W-1:0]     data_out,
  output logic                 valid,
  output logic                 err,
  output logic [NUM_FIFOS-1:0] sat
);

  localparam int unsigned      SUM_W     = CNT_W + $clog2(NUM_FIFOS + 1);
  localparam logic [IDX_W-1:0] IDX_TOT_P = IDX_W'(NUM_FIFOS);

  logic [CNT_W-1:0] cnt [NUM_FIFOS];

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (init),
      .en    (pop[g] & ~empty[g]),
      .cnt   (cnt[g]),
      .sat   (sat[g])
    );
  end

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] sel;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      sum = sum + SUM_W'(cnt[i]);
    end
    total = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
    sel = total;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel = cnt[i];
      end
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             open;

  assign open = idle & ~init;

  // Response is registered at the req edge, so data_out carries the pre-increment count.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (open) state_d = ST_READY;
      end
      ST_READY: begin
        if (!open) begin
          state_d = ST_WAIT;
        end else if (req) begin
          state_d = ST_RESP;
          if (idx <= IDX_TOT_P) begin
            valid_d = 1'b1;
            data_d  = sel;
          end else begin
            err_d  = 1'b1;
            data_d = '0;
          end
        end
      end
      ST_RESP: begin
        state_d = open ? ST_READY : ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pop_counter.sv
// Directed scoreboard bench for pop_counter: stimulus pushes expected responses, a monitor pops and compares.
module tb_pop_counter;

  logic       clk = 1'b0;
  logic       reset, init, idle, req;
  logic [3:0] pop, empty, sat;
  logic [2:0] idx;
  logic [4:0] data_out;
  logic       valid, err;

  typedef struct {
    logic       is_err;
    logic [4:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pop_counter #(
    .NUM_FIFOS (4),
    .CNT_W     (5),
    .IDX_W     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .idle     (idle),
    .pop      (pop),
    .empty    (empty),
    .req      (req),
    .idx      (idx),
    .data_out (data_out),
    .valid    (valid),
    .err      (err),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid || err) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got valid=%0b err=%0b data=%0d, required no response",
                 valid, err, data_out);
      end else begin
        e = sb.pop_front();
        check("resp_valid", 32'(valid), 32'(!e.is_err));
        check("resp_err", 32'(err), 32'(e.is_err));
        check(e.is_err ? "err_data" : "resp_data", 32'(data_out), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_err, input logic [4:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    sb.push_back(e);
  endtask

  // Issue one read from READY, then spend the RESP cycle and confirm it was answered.
  task automatic do_req(input logic [2:0] i, input logic is_err, input logic [4:0] data);
    push(is_err, data);
    idx = i;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    check("resp_seen", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; idle = 1'b0; req = 1'b0;
    pop = '0; empty = '0; idx = '0;

    // Reset then init
    repeat (2) tick();
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    reset = 1'b0;
    init  = 1'b1;
    pop   = 4'b1111;
    repeat (3) tick();
    pop  = '0;
    init = 1'b0;
    idle = 1'b1;
    tick();
    do_req(3'd0, 1'b0, 5'd0);
    check("init_sat", 32'(sat), 32'd0);

    // Basic count: c0=4, c2=2
    pop = 4'b0101;
    repeat (2) tick();
    pop = 4'b0001;
    repeat (2) tick();
    pop = '0;
    do_req(3'd0, 1'b0, 5'd4);
    do_req(3'd2, 1'b0, 5'd2);
    do_req(3'd4, 1'b0, 5'd6);

    // Empty filter: c1=3
    pop = 4'b0010;
    repeat (3) tick();
    empty = 4'b0010;
    repeat (2) tick();
    pop = '0; empty = '0;
    do_req(3'd1, 1'b0, 5'd3);
    do_req(3'd4, 1'b0, 5'd9);

    // req while not idle is dropped
    idle = 1'b0;
    tick();
    idx = 3'd0;
    req = 1'b1;
    repeat (2) tick();
    req  = 1'b0;
    idle = 1'b1;
    tick();
    check("gated_none", 32'(sb.size()), 32'd0);

    // Out-of-range index
    do_req(3'd5, 1'b1, 5'd0);

    // req held for 4 cycles -> two responses
    push(1'b0, 5'd4);
    push(1'b0, 5'd4);
    idx = 3'd0;
    req = 1'b1;
    repeat (4) tick();
    req = 1'b0;
    tick();
    check("held_two", 32'(sb.size()), 32'd0);

    // Same-cycle pop returns the old value
    push(1'b0, 5'd4);
    pop = 4'b0001;
    idx = 3'd0;
    req = 1'b1;
    tick();
    pop = '0;
    req = 1'b0;
    tick();
    check("samecyc_seen", 32'(sb.size()), 32'd0);
    do_req(3'd0, 1'b0, 5'd5);

    // Saturation of FIFO 3
    pop = 4'b1000;
    repeat (40) tick();
    pop = '0;
    check("sat3", 32'(sat), 32'b1000);
    do_req(3'd3, 1'b0, 5'd31);
    do_req(3'd4, 1'b0, 5'd31);
    init = 1'b1;
    tick();
    init = 1'b0;
    check("init_clr_sat", 32'(sat), 32'd0);
    tick();
    do_req(3'd3, 1'b0, 5'd0);
    do_req(3'd4, 1'b0, 5'd0);

    // Reset right after a read is sampled
    pop = 4'b0001;
    repeat (2) tick();
    pop = '0;
    push(1'b0, 5'd2);
    idx = 3'd0;
    req = 1'b1;
    tick();
    req   = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_sat", 32'(sat), 32'd0);
    check("midrst_seen", 32'(sb.size()), 32'd0);
    reset = 1'b0;
    req   = 1'b1;
    tick();
    req = 1'b0;
    repeat (2) tick();
    do_req(3'd0, 1'b0, 5'd0);
    do_req(3'd4, 1'b0, 5'd0);

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
